// File: rtl/uart_ascii_tx.sv
// uart_ascii_tx: FIFO-buffered UART transmitter (8N1, LSB first) for the ASCII loopback line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_ascii_tx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  ascii_code,
    input  logic                        ascii_valid,
    output logic                        ascii_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_next;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             baud_last;
    logic             tx_next;
    logic             busy_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign fifo_empty  = (fifo_count == '0);
    assign fifo_full   = (fifo_count == COUNT_FULL);
    assign ascii_ready = !fifo_full;
    assign push        = ascii_valid && !fifo_full;
    assign baud_last   = (baud_cnt == BAUD_LAST);

    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + COUNT_ONE;
            2'b01:   count_next = fifo_count - COUNT_ONE;
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            fifo_count <= count_next;
        end
    end

    // Storage carries no reset; validity is defined purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= ascii_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= next_state;
            tx    <= tx_next;
            busy  <= busy_next;
            if (pop) begin
                shift    <= fifo_mem[rd_ptr];
                bit_cnt  <= '0;
                baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^fifo_mem[rd_ptr];
`endif
            end else if (state == IDLE) begin
                baud_cnt <= '0;
            end else if (baud_last) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + BAUD_ONE;
            end
        end
    end

    // A pop on the last stop clock chains the next frame with no idle gap.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (baud_last)
                    next_state = DATA;
            end
            DATA: begin
                if (baud_last && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last)
                    next_state = STOP;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_next   = 1'b1;
        busy_next = (next_state != IDLE) || (count_next != '0);
        case (state)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

endmodule
